// File: rtl/nmr_pulse_analyzer.sv
// Receive-side measurement of the NMR TX gate pulse train: recovers A/B pulse
// lengths, A-B and B-B delays and the B-pulse count of one sequence per arm.
module nmr_pulse_analyzer #(
   parameter int W       = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pulse_in,
   input  logic         arm,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] a_len,
   output logic [W-1:0] b_len,
   output logic [W-1:0] ab_dly,
   output logic [W-1:0] bb_dly,
   output logic [W-1:0] bb_cnt,
   output logic         mismatch,
   output logic         overflow
);

   localparam logic [W-1:0] CMAX = '1;
   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] TO   = W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, WAIT_LOW, WAIT_A, A_HI, AB_LO, B_HI, BB_LO, DONE
   } state_t;

   typedef struct packed {
      logic [W-1:0] a_len;
      logic [W-1:0] b_len;
      logic [W-1:0] ab_dly;
      logic [W-1:0] bb_dly;
      logic [W-1:0] bb_cnt;
      logic         mismatch;
      logic         overflow;
   } res_t;

   state_t       state_q, state_d;
   logic         p_q;
   logic [W-1:0] cnt_q, cnt_d;
   res_t         res_q, res_d;

   logic         cnt_sat, bbc_sat;
   logic [W-1:0] cnt_inc, bbc_inc;

   // Saturating increments: the held value stays at CMAX instead of wrapping.
   assign cnt_sat = (cnt_q == CMAX);
   assign cnt_inc = cnt_sat ? CMAX : cnt_q + ONE;
   assign bbc_sat = (res_q.bb_cnt == CMAX);
   assign bbc_inc = bbc_sat ? CMAX : res_q.bb_cnt + ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         p_q     <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= pulse_in;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Every level change reloads the counter with 1, so the sample that shows
   // the new level is already counted and no cycle is lost at transitions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE, DONE: begin
            if (arm) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (!p_q) state_d = WAIT_A;
         end
         WAIT_A: begin
            if (p_q) begin
               state_d = A_HI;
               cnt_d   = ONE;
            end
         end
         A_HI: begin
            if (p_q) begin
               cnt_d = cnt_inc;
               if (cnt_sat) res_d.overflow = 1'b1;
            end else begin
               res_d.a_len = cnt_q;
               cnt_d       = ONE;
               state_d     = AB_LO;
            end
         end
         AB_LO: begin
            if (p_q) begin
               res_d.ab_dly = cnt_q;
               cnt_d        = ONE;
               state_d      = B_HI;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_sat) res_d.overflow = 1'b1;
               if (cnt_inc == TO) state_d = DONE;
            end
         end
         B_HI: begin
            if (p_q) begin
               cnt_d = cnt_inc;
               if (cnt_sat) res_d.overflow = 1'b1;
            end else begin
               res_d.bb_cnt = bbc_inc;
               if (bbc_sat) res_d.overflow = 1'b1;
               if (res_q.bb_cnt == '0) res_d.b_len = cnt_q;
               else if (cnt_q != res_q.b_len) res_d.mismatch = 1'b1;
               cnt_d   = ONE;
               state_d = BB_LO;
            end
         end
         BB_LO: begin
            if (p_q) begin
               // bb_cnt is 1 only during the gap after the first B pulse
               if (res_q.bb_cnt == ONE) res_d.bb_dly = cnt_q;
               else if (cnt_q != res_q.bb_dly) res_d.mismatch = 1'b1;
               cnt_d   = ONE;
               state_d = B_HI;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_sat) res_d.overflow = 1'b1;
               if (cnt_inc == TO) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE) && (state_q != DONE);
   assign done     = (state_q == DONE);
   assign a_len    = res_q.a_len;
   assign b_len    = res_q.b_len;
   assign ab_dly   = res_q.ab_dly;
   assign bb_dly   = res_q.bb_dly;
   assign bb_cnt   = res_q.bb_cnt;
   assign mismatch = res_q.mismatch;
   assign overflow = res_q.overflow;

endmodule

// File: tb/tb_nmr_pulse_analyzer.sv
// Scoreboarded bench for nmr_pulse_analyzer: two instances (W=16/TIMEOUT=1000
// and W=8/TIMEOUT=50) driven with directed and random gate sequences.
module tb_nmr_pulse_analyzer;

   localparam int TO0 = 1000;
   localparam int TO1 = 50;

   logic clk = 1'b0;
   logic rst;
   logic arm_s [2];
   logic pulse_s [2];

   logic        busy0, done0, mm0, ov0;
   logic [15:0] a0, b0, ab0, bb0, c0;
   logic        busy1, done1, mm1, ov1;
   logic [7:0]  a1, b1, ab1, bb1, c1;

   always #5 clk = ~clk;

   nmr_pulse_analyzer #(.W(16), .TIMEOUT(TO0)) dut0 (
      .clk(clk), .rst(rst), .pulse_in(pulse_s[0]), .arm(arm_s[0]),
      .busy(busy0), .done(done0), .a_len(a0), .b_len(b0), .ab_dly(ab0),
      .bb_dly(bb0), .bb_cnt(c0), .mismatch(mm0), .overflow(ov0));

   nmr_pulse_analyzer #(.W(8), .TIMEOUT(TO1)) dut1 (
      .clk(clk), .rst(rst), .pulse_in(pulse_s[1]), .arm(arm_s[1]),
      .busy(busy1), .done(done1), .a_len(a1), .b_len(b1), .ab_dly(ab1),
      .bb_dly(bb1), .bb_cnt(c1), .mismatch(mm1), .overflow(ov1));

   typedef struct {
      longint a_len, b_len, ab, bb, cnt;
      bit     mm, ov;
      longint dcyc;
   } exp_t;

   exp_t   q0[$], q1[$];
   longint cyc = 0;
   int     n_vec = 0, n_err = 0;

   // current sequence description
   int s_a, s_ab;
   int s_b[$], s_g[$];
   bit s_xarm;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int to_of(input int sel);
      return sel ? TO1 : TO0;
   endfunction

   // Reference: results follow directly from the pulse/gap list.
   task automatic push_exp(input int sel, input longint dcyc);
      exp_t   e;
      longint mx;
      int     nb;
      mx = sel ? 255 : 65535;
      nb = s_b.size();
      e = '{default: 0};
      e.dcyc  = dcyc;
      e.a_len = (s_a > mx) ? mx : s_a;
      e.ov    = (s_a > mx);
      if (nb > 0) begin
         e.ab    = (s_ab > mx) ? mx : s_ab;
         e.b_len = (s_b[0] > mx) ? mx : s_b[0];
         e.cnt   = (nb > mx) ? mx : nb;
         for (int i = 0; i < nb; i++) begin
            if (s_b[i] > mx) e.ov = 1;
            if (((s_b[i] > mx) ? mx : s_b[i]) != e.b_len) e.mm = 1;
         end
         if (nb >= 2) e.bb = s_g[0];
         for (int i = 1; i < nb - 1; i++)
            if (s_g[i] != s_g[0]) e.mm = 1;
      end
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
   endtask

   function automatic int body_len();
      int n;
      n = s_a;
      if (s_b.size() > 0) begin
         n += s_ab;
         foreach (s_b[i]) n += s_b[i];
         foreach (s_g[i]) n += s_g[i];
      end
      return n;
   endfunction

   task automatic drive(input int sel, input logic lvl, input int n);
      repeat (n) begin
         pulse_s[sel] = lvl;
         @(negedge clk);
      end
   endtask

   task automatic body(input int sel);
      drive(sel, 1'b1, s_a);
      if (s_b.size() > 0) begin
         if (s_xarm) begin
            pulse_s[sel] = 1'b0;
            arm_s[sel]   = 1'b1;
            @(negedge clk);
            arm_s[sel]   = 1'b0;
            drive(sel, 1'b0, s_ab - 1);
         end else begin
            drive(sel, 1'b0, s_ab);
         end
         foreach (s_b[i]) begin
            drive(sel, 1'b1, s_b[i]);
            if (i < s_b.size() - 1) drive(sel, 1'b0, s_g[i]);
         end
      end
      drive(sel, 1'b0, to_of(sel) + 3);
   endtask

   task automatic run_seq(input int sel, input logic arm_lvl, input int post_hi, input int lead_lo);
      longint t0;
      t0 = cyc;
      push_exp(sel, t0 + 1 + post_hi + lead_lo + body_len() + to_of(sel) + 1);
      pulse_s[sel] = arm_lvl;
      arm_s[sel]   = 1'b1;
      @(negedge clk);
      arm_s[sel]   = 1'b0;
      chk("busy_after_arm", sel ? busy1 : busy0, 1);
      chk("done_after_arm", sel ? done1 : done0, 0);
      drive(sel, arm_lvl, post_hi);
      drive(sel, 1'b0, lead_lo);
      body(sel);
   endtask

   task automatic set_seq(input int a, input int ab, input int nb, input int b, input int g);
      s_a = a; s_ab = ab; s_xarm = 0;
      s_b.delete(); s_g.delete();
      for (int i = 0; i < nb; i++) s_b.push_back(b);
      for (int i = 0; i < nb - 1; i++) s_g.push_back(g);
   endtask

   task automatic gen_rand(input int sel);
      int nb, bb, gg, amax, lmax, gmax;
      amax = sel ? 300 : 40;
      lmax = sel ? 30 : 40;
      gmax = sel ? TO1 - 1 : 200;
      nb = $urandom_range(0, 4);
      bb = $urandom_range(1, lmax);
      gg = $urandom_range(1, gmax);
      s_a    = $urandom_range(1, amax);
      s_ab   = $urandom_range(1, gmax);
      s_xarm = $urandom_range(0, 1);
      s_b.delete(); s_g.delete();
      for (int i = 0; i < nb; i++)
         s_b.push_back(($urandom_range(0, 2) != 0) ? bb : $urandom_range(1, lmax));
      for (int i = 0; i < nb - 1; i++)
         s_g.push_back(($urandom_range(0, 2) != 0) ? gg : $urandom_range(1, gmax));
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, ".busy0"}, busy0, 0); chk({tag, ".done0"}, done0, 0);
      chk({tag, ".a0"}, a0, 0);       chk({tag, ".b0"}, b0, 0);
      chk({tag, ".ab0"}, ab0, 0);     chk({tag, ".bb0"}, bb0, 0);
      chk({tag, ".cnt0"}, c0, 0);     chk({tag, ".mm0"}, mm0, 0);
      chk({tag, ".ov0"}, ov0, 0);
   endtask

   // monitors: compare on each rising edge of done
   logic done0_d = 1'b0, done1_d = 1'b0;

   always @(negedge clk) begin : mon0
      exp_t e;
      if (done0 && !done0_d) begin
         if (q0.size() == 0) chk("d0.unexpected_done", 1, 0);
         else begin
            e = q0.pop_front();
            chk("d0.a_len", a0, e.a_len);   chk("d0.b_len", b0, e.b_len);
            chk("d0.ab_dly", ab0, e.ab);    chk("d0.bb_dly", bb0, e.bb);
            chk("d0.bb_cnt", c0, e.cnt);    chk("d0.mismatch", mm0, e.mm);
            chk("d0.overflow", ov0, e.ov);  chk("d0.done_cycle", cyc, e.dcyc);
            chk("d0.busy_at_done", busy0, 0);
         end
      end
      done0_d = done0;
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (done1 && !done1_d) begin
         if (q1.size() == 0) chk("d1.unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            chk("d1.a_len", a1, e.a_len);   chk("d1.b_len", b1, e.b_len);
            chk("d1.ab_dly", ab1, e.ab);    chk("d1.bb_dly", bb1, e.bb);
            chk("d1.bb_cnt", c1, e.cnt);    chk("d1.mismatch", mm1, e.mm);
            chk("d1.overflow", ov1, e.ov);  chk("d1.done_cycle", cyc, e.dcyc);
            chk("d1.busy_at_done", busy1, 0);
         end
      end
      done1_d = done1;
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      arm_s[0] = 1'b0; arm_s[1] = 1'b0;
      pulse_s[0] = 1'b0; pulse_s[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero0("reset");
      chk("reset.busy1", busy1, 0); chk("reset.done1", done1, 0);
      chk("reset.a1", a1, 0);       chk("reset.ov1", ov1, 0);
      rst = 1'b1;
      @(negedge clk);

      // nominal
      set_seq(10, 120, 5, 20, 60);
      run_seq(0, 1'b0, 0, 3);
      // jitter on the second B pulse
      set_seq(10, 120, 3, 20, 60);
      s_b[1] = 21;
      run_seq(0, 1'b0, 0, 3);
      // arm while the gate is already high: 5 of 10 cycles gone
      set_seq(10, 120, 2, 20, 60);
      drive(0, 1'b1, 5);
      run_seq(0, 1'b1, 4, 20);
      // A-only and saturation on the narrow instance
      set_seq(7, 1, 0, 0, 0);
      run_seq(1, 1'b0, 0, 3);
      set_seq(300, 30, 3, 20, 40);
      run_seq(1, 1'b0, 0, 3);

      // reset in the middle of a B-B gap
      arm_s[0] = 1'b1;
      @(negedge clk);
      arm_s[0] = 1'b0;
      drive(0, 1'b0, 3);
      drive(0, 1'b1, 10);
      drive(0, 1'b0, 120);
      drive(0, 1'b1, 20);
      drive(0, 1'b0, 30);
      rst = 1'b0;
      #1;
      chk_zero0("mid_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_seq(10, 120, 5, 20, 60);
      run_seq(0, 1'b0, 0, 3);

      for (int i = 0; i < 8; i++) begin
         gen_rand(0);
         run_seq(0, 1'b0, 0, 3);
      end
      for (int i = 0; i < 30; i++) begin
         gen_rand(1);
         run_seq(1, 1'b0, 0, 3);
      end

      repeat (5) @(negedge clk);
      chk("pending_dut0", q0.size(), 0);
      chk("pending_dut1", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
